// File: rtl/node_lane_array_pkg.sv
// Shared types for the lane array: FSM encoding, op codes, instruction layout
// and the accumulator width formula.
package node_lane_array_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MAC     = 2'd0,
    OP_ADD     = 2'd1,
    OP_SUB     = 2'd2,
    OP_ABSDIFF = 2'd3
  } op_e;

  typedef struct packed {
    logic relu;
    op_e  op;
  } instr_t;

  function automatic int acc_w(input int data_w, input int guard_w);
    return 2 * data_w + guard_w;
  endfunction
endpackage

// File: rtl/node_lane_array_if.sv
// Config, operand-bus and result handshake bundle for one lane-array block.
interface node_lane_array_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 12
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [2:0]              cfg_instr;
  logic [TAG_W-1:0]        cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim;
  logic                    bus_valid;
  logic [TAG_W-1:0]        bus_tag0, bus_tag1;
  logic [LANES*DATA_W-1:0] bus_d0, bus_d1;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] d_out;

  modport master (
    output cfg_valid, cfg_instr, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag0, bus_tag1, bus_d0, bus_d1, out_ready,
    input  cfg_ready, out_valid, d_out
  );

  modport slave (
    input  cfg_valid, cfg_instr, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag0, bus_tag1, bus_d0, bus_d1, out_ready,
    output cfg_ready, out_valid, d_out
  );
endinterface

// File: rtl/node_lane_array_lane.sv
// One lane: operand slot data, accumulator, op datapath and saturate/relu
// output register. Capture/update strobes come from the shared control.
module node_lane
  import node_lane_array_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 14,
  parameter int GUARD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_a,
  input  logic              cap_b,
  input  logic              sel_a,
  input  logic              sel_b,
  input  logic              upd,
  input  logic              ld,
  input  instr_t            instr,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d_out
);
  localparam int ACC_W = acc_w(DATA_W, GUARD_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0]   a, b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W:0]     sum, diff, adiff;
  logic signed [ACC_W-1:0]    acc, delta;
  logic        [DATA_W-1:0]   res;

  always_comb begin
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    sum   = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    diff  = (DATA_W+1)'(a) - (DATA_W+1)'(b);
    adiff = diff[DATA_W] ? -diff : diff;
    delta = '0;
    unique case (instr.op)
      OP_MAC:     delta = ACC_W'(prod >>> FRAC_W);  // truncates toward -inf, no rounding
      OP_ADD:     delta = ACC_W'(sum);
      OP_SUB:     delta = ACC_W'(diff);
      OP_ABSDIFF: delta = ACC_W'(adiff);
    endcase
  end

  always_comb begin
    if (instr.relu && acc[ACC_W-1]) res = '0;
    else if (acc > SAT_MAX)         res = SAT_MAX[DATA_W-1:0];
    else if (acc < SAT_MIN)         res = SAT_MIN[DATA_W-1:0];
    else                            res = acc[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      d_out <= '0;
    end else begin
      if (cap_a) a <= sel_a ? d1 : d0;
      if (cap_b) b <= sel_b ? d1 : d0;
      if (clr)      acc <= '0;
      else if (upd) acc <= acc + delta;
      if (ld) d_out <= res;
    end
  end
endmodule

// File: rtl/node_lane_array.sv
// Chainable lane-array block: claims one config, gathers tagged operand pairs
// from two broadcast buses, accumulates per lane, then presents the result.
module node_lane_array
  import node_lane_array_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 14,
  parameter int TAG_W   = 12,
  parameter int GUARD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_enable,
  output logic              next_enable,
  output logic              busy,
  node_lane_array_if.slave  io
);
  state_e           state, state_nxt;
  instr_t           instr;
  logic [TAG_W-1:0] tag_a, tag_b, stride_a, stride_b, iter_cnt, iter_lim;
  logic             full_a, full_b;
  logic             cfg_fire, last, run, upd;
  logic             m0a, m1a, m0b, m1b, cap_a, cap_b, sel_a, sel_b;

  logic [LANES-1:0][DATA_W-1:0] bus0, bus1, lane_out;

  assign busy          = state != S_IDLE;
  // Idle blocks hold back the grant so only the first idle block sees cfg_ready.
  assign next_enable   = prev_enable & busy;
  assign io.cfg_ready  = (state == S_IDLE) & prev_enable;
  assign io.out_valid  = state == S_DONE;
  assign cfg_fire      = io.cfg_valid & io.cfg_ready;

  // The RUN cycle that sees the limit reached loads d_out and leaves for DONE.
  assign last  = (state == S_RUN) && (iter_cnt == iter_lim);
  assign run   = (state == S_RUN) && !last;
  assign upd   = run & full_a & full_b;

  assign m0a   = io.bus_tag0 == tag_a;
  assign m1a   = io.bus_tag1 == tag_a;
  assign m0b   = io.bus_tag0 == tag_b;
  assign m1b   = io.bus_tag1 == tag_b;
  assign cap_a = run & io.bus_valid & ~full_a & (m0a | m1a);
  assign cap_b = run & io.bus_valid & ~full_b & (m0b | m1b);
  assign sel_a = ~m0a;
  assign sel_b = ~m0b;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cfg_fire)     state_nxt = S_RUN;
      S_RUN:   if (last)         state_nxt = S_DONE;
      S_DONE:  if (io.out_ready) state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr    <= '0;
      tag_a    <= '0;
      tag_b    <= '0;
      stride_a <= '0;
      stride_b <= '0;
      iter_cnt <= '0;
      iter_lim <= '0;
      full_a   <= 1'b0;
      full_b   <= 1'b0;
    end else if (cfg_fire) begin
      instr    <= instr_t'(io.cfg_instr);
      tag_a    <= io.cfg_tag_a;
      tag_b    <= io.cfg_tag_b;
      stride_a <= io.cfg_stride_a;
      stride_b <= io.cfg_stride_b;
      iter_lim <= io.cfg_iter_lim;
      iter_cnt <= '0;
      full_a   <= 1'b0;
      full_b   <= 1'b0;
    end else if (upd) begin
      full_a   <= 1'b0;
      full_b   <= 1'b0;
      tag_a    <= tag_a + stride_a;
      tag_b    <= tag_b + stride_b;
      iter_cnt <= iter_cnt + TAG_W'(1);
    end else begin
      if (cap_a) full_a <= 1'b1;
      if (cap_b) full_b <= 1'b1;
    end
  end

  assign bus0     = io.bus_d0;
  assign bus1     = io.bus_d1;
  assign io.d_out = lane_out;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    node_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .GUARD_W(GUARD_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (cfg_fire),
      .cap_a(cap_a),
      .cap_b(cap_b),
      .sel_a(sel_a),
      .sel_b(sel_b),
      .upd  (upd),
      .ld   (last),
      .instr(instr),
      .d0   (bus0[i]),
      .d1   (bus1[i]),
      .d_out(lane_out[i])
    );
  end
endmodule

// File: tb/tb_node_lane_array.sv
// Bench for node_lane_array: directed vector table, corner sequences, a
// two-block chain, and random configs checked against an arithmetic model.
module tb_node_lane_array;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int TW    = 12;
  localparam int BW    = LANES * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pe0 = 1'b1;
  logic ne0, ne1, busy0, busy1;
  int   checks = 0;
  int   errors = 0;

  node_lane_array_if #(.LANES(LANES), .DATA_W(DW), .TAG_W(TW)) if0 ();
  node_lane_array_if #(.LANES(LANES), .DATA_W(DW), .TAG_W(TW)) if1 ();

  node_lane_array #(.LANES(LANES), .DATA_W(DW), .FRAC_W(14), .TAG_W(TW), .GUARD_W(8)) dut0 (
    .clk(clk), .rst(rst), .prev_enable(pe0), .next_enable(ne0), .busy(busy0), .io(if0.slave));
  node_lane_array #(.LANES(LANES), .DATA_W(DW), .FRAC_W(14), .TAG_W(TW), .GUARD_W(8)) dut1 (
    .clk(clk), .rst(rst), .prev_enable(ne0), .next_enable(ne1), .busy(busy1), .io(if1.slave));

  always #5 clk = ~clk;

  // Both blocks share the config broadcast and operand buses.
  assign if1.cfg_valid    = if0.cfg_valid;
  assign if1.cfg_instr    = if0.cfg_instr;
  assign if1.cfg_tag_a    = if0.cfg_tag_a;
  assign if1.cfg_tag_b    = if0.cfg_tag_b;
  assign if1.cfg_stride_a = if0.cfg_stride_a;
  assign if1.cfg_stride_b = if0.cfg_stride_b;
  assign if1.cfg_iter_lim = if0.cfg_iter_lim;
  assign if1.bus_valid    = if0.bus_valid;
  assign if1.bus_tag0     = if0.bus_tag0;
  assign if1.bus_tag1     = if0.bus_tag1;
  assign if1.bus_d0       = if0.bus_d0;
  assign if1.bus_d1       = if0.bus_d1;

  typedef struct {
    logic [2:0]    ins;
    logic [TW-1:0] lim;
    logic [DW-1:0] a, b, exp;
  } vec_t;

  vec_t          vt[11];
  longint        acc_m[LANES];
  logic [BW-1:0] xa, xb, ya, yb, e0, e1;
  logic [2:0]    ins;
  logic [TW-1:0] ta, tb_, sa, sb, lim;
  logic          seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [TW-1:0] noise(input logic [TW-1:0] x, input logic [TW-1:0] y);
    logic [TW-1:0] n;
    n = TW'($urandom);
    while (n == x || n == y) n = n + TW'(1);
    return n;
  endfunction

  function automatic longint term(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      2'd0:    return (x * y) >>> 14;
      2'd1:    return x + y;
      2'd2:    return x - y;
      default: return (x > y) ? x - y : y - x;
    endcase
  endfunction

  function automatic logic [DW-1:0] sat(input longint v, input logic relu);
    if (relu && v < 0) return '0;
    if (v > 32767)     return 16'h7FFF;
    if (v < -32768)    return 16'h8000;
    return v[DW-1:0];
  endfunction

  function automatic void model_clr();
    for (int i = 0; i < LANES; i++) acc_m[i] = 0;
  endfunction

  function automatic void add_pair(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int i = 0; i < LANES; i++) acc_m[i] += term(op, a[i*DW +: DW], b[i*DW +: DW]);
  endfunction

  function automatic logic [BW-1:0] model_out(input logic relu);
    logic [BW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = sat(acc_m[i], relu);
    return r;
  endfunction

  task automatic cfg_set(input logic [2:0] i, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic [TW-1:0] s_a, input logic [TW-1:0] s_b, input logic [TW-1:0] l);
    if0.cfg_instr    = i;
    if0.cfg_tag_a    = a;
    if0.cfg_tag_b    = b;
    if0.cfg_stride_a = s_a;
    if0.cfg_stride_b = s_b;
    if0.cfg_iter_lim = l;
  endtask

  task automatic cfg(input logic [2:0] i, input logic [TW-1:0] a, input logic [TW-1:0] b,
                     input logic [TW-1:0] s_a, input logic [TW-1:0] s_b, input logic [TW-1:0] l);
    cfg_set(i, a, b, s_a, s_b, l);
    if0.cfg_valid = 1'b1;
    tick();
    if0.cfg_valid = 1'b0;
  endtask

  task automatic bus(input logic v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                     input logic [BW-1:0] d0, input logic [BW-1:0] d1);
    if0.bus_valid = v;
    if0.bus_tag0  = t0;
    if0.bus_tag1  = t1;
    if0.bus_d0    = d0;
    if0.bus_d1    = d1;
    tick();
  endtask

  // mode 0: a@bus0 b@bus1; 1: crossed; 2: a then b a cycle later, with a
  // repeated a-tag ignored; 3: shared tag, both slots from bus0.
  // Trailing cycle repeats the tags with junk while both slots are full.
  task automatic pair(input int mode, input logic [TW-1:0] t_a, input logic [TW-1:0] t_b,
                      input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [TW-1:0] nz;
    nz = noise(t_a, t_b);
    case (mode)
      0: bus(1'b1, t_a, t_b, a, b);
      1: bus(1'b1, t_b, t_a, b, a);
      2: begin
        bus(1'b1, t_a, nz, a, rnd_bus());
        bus(1'b1, t_a, t_b, rnd_bus(), b);
      end
      default: bus(1'b1, t_a, nz, a, rnd_bus());
    endcase
    bus(1'b1, t_a, t_b, rnd_bus(), rnd_bus());
  endtask

  task automatic wait_done(input string nm, input logic [BW-1:0] exp, input int dly);
    int n;
    n = 0;
    while (!if0.out_valid && n < 8) begin
      tick();
      n++;
    end
    chk1({nm, "_vld"}, if0.out_valid, 1'b1);
    chkw({nm, "_dout"}, if0.d_out, exp);
    for (int k = 0; k < dly; k++) bus(1'b1, TW'($urandom), TW'($urandom), rnd_bus(), rnd_bus());
    if (dly > 0) begin
      chk1({nm, "_hold_vld"}, if0.out_valid, 1'b1);
      chkw({nm, "_hold_dout"}, if0.d_out, exp);
    end
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    if0.bus_valid = 1'b0;
    chk1({nm, "_vld_drop"}, if0.out_valid, 1'b0);
    chk1({nm, "_idle"}, busy0, 1'b0);
    chkw({nm, "_keep"}, if0.d_out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{3'b000, 12'd3, 16'h2000, 16'h2000, 16'h3000};
    vt[1]  = '{3'b000, 12'd4, 16'h4000, 16'h2000, 16'h7FFF};
    vt[2]  = '{3'b100, 12'd4, 16'h4000, 16'hE000, 16'h0000};
    vt[3]  = '{3'b000, 12'd4, 16'h4000, 16'hE000, 16'h8000};
    vt[4]  = '{3'b001, 12'd2, 16'h1000, 16'h0800, 16'h3000};
    vt[5]  = '{3'b010, 12'd2, 16'h1000, 16'h3000, 16'hC000};
    vt[6]  = '{3'b011, 12'd2, 16'h1000, 16'h3000, 16'h4000};
    vt[7]  = '{3'b010, 12'd1, 16'h8000, 16'h7FFF, 16'h8000};
    vt[8]  = '{3'b101, 12'd3, 16'hF000, 16'hF000, 16'h0000};
    vt[9]  = '{3'b001, 12'd0, 16'h1234, 16'h1234, 16'h0000};
    vt[10] = '{3'b000, 12'd2, 16'hFFFF, 16'h0001, 16'hFFFE};

    if0.cfg_valid = 1'b0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    cfg_set(3'b000, '0, '0, '0, '0, '0);
    if0.bus_valid = 1'b0;
    if0.bus_tag0  = '0;
    if0.bus_tag1  = '0;
    if0.bus_d0    = '0;
    if0.bus_d1    = '0;

    tick();
    tick();
    rst = 1'b1;
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_vld", if0.out_valid, 1'b0);
    chk1("rst_rdy0", if0.cfg_ready, 1'b1);
    chk1("rst_rdy1", if1.cfg_ready, 1'b0);
    chk1("rst_ne0", ne0, 1'b0);
    chkw("rst_dout", if0.d_out, '0);

    for (int v = 0; v < 11; v++) begin
      cfg(vt[v].ins, 12'h010, 12'h020, 12'd1, 12'd1, vt[v].lim);
      chk1($sformatf("vec%0d_acc", v), busy0, 1'b1);
      for (int k = 0; k < int'(vt[v].lim); k++)
        pair(k % 3, TW'(12'h010 + k), TW'(12'h020 + k), {LANES{vt[v].a}}, {LANES{vt[v].b}});
      wait_done($sformatf("vec%0d", v), {LANES{vt[v].exp}}, v % 3);
    end

    // zero-iteration config: RUN one cycle, DONE on the second
    cfg(3'b000, 12'h030, 12'h031, 12'd1, 12'd1, 12'd0);
    chk1("lim0_c1_vld", if0.out_valid, 1'b0);
    tick();
    chk1("lim0_c2_vld", if0.out_valid, 1'b1);
    wait_done("lim0", '0, 0);

    // cross-bus capture then tag_a wrap 0xFFF+2 -> 0x001
    xa = rnd_bus(); xb = rnd_bus(); ya = rnd_bus(); yb = rnd_bus();
    cfg(3'b001, 12'hFFF, 12'h055, 12'd2, 12'd1, 12'd2);
    bus(1'b1, 12'h055, 12'hFFF, xb, xa);
    bus(1'b0, 12'h000, 12'h000, '0, '0);
    bus(1'b1, 12'h000, 12'h056, rnd_bus(), yb);
    bus(1'b1, 12'h001, 12'h056, ya, rnd_bus());
    bus(1'b0, 12'h000, 12'h000, '0, '0);
    model_clr();
    add_pair(2'd1, xa, xb);
    add_pair(2'd1, ya, yb);
    wait_done("wrap", model_out(1'b0), 1);

    // two chained blocks claim back-to-back configs in order
    xa = rnd_bus(); xb = rnd_bus(); ya = rnd_bus(); yb = rnd_bus();
    cfg_set(3'b001, 12'h100, 12'h101, 12'd1, 12'd1, 12'd1);
    if0.cfg_valid = 1'b1;
    tick();
    chk1("chain_b0_busy", busy0, 1'b1);
    chk1("chain_b1_idle", busy1, 1'b0);
    chk1("chain_b1_rdy", if1.cfg_ready, 1'b1);
    chk1("chain_b0_nrdy", if0.cfg_ready, 1'b0);
    cfg_set(3'b001, 12'h200, 12'h201, 12'd1, 12'd1, 12'd1);
    tick();
    if0.cfg_valid = 1'b0;
    chk1("chain_b1_busy", busy1, 1'b1);
    chk1("chain_ne1", ne1, 1'b1);
    bus(1'b1, 12'h200, 12'h201, ya, yb);
    bus(1'b0, 12'h000, 12'h000, '0, '0);
    bus(1'b1, 12'h100, 12'h101, xa, xb);
    bus(1'b0, 12'h000, 12'h000, '0, '0);
    model_clr();
    add_pair(2'd1, xa, xb);
    e0 = model_out(1'b0);
    model_clr();
    add_pair(2'd1, ya, yb);
    e1 = model_out(1'b0);
    for (int n = 0; n < 8 && !(if0.out_valid && if1.out_valid); n++) tick();
    for (int k = 0; k < 5; k++) begin
      chk1($sformatf("chain_hold%0d_v0", k), if0.out_valid, 1'b1);
      chk1($sformatf("chain_hold%0d_v1", k), if1.out_valid, 1'b1);
      chkw($sformatf("chain_hold%0d_d0", k), if0.d_out, e0);
      chkw($sformatf("chain_hold%0d_d1", k), if1.d_out, e1);
      tick();
    end
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    chk1("chain_rel_v0", if0.out_valid, 1'b0);
    chk1("chain_rel_v1", if1.out_valid, 1'b0);
    chk1("chain_rel_b1", busy1, 1'b0);

    // reset after 2 of 4 iterations aborts with no result
    cfg(3'b000, 12'h010, 12'h020, 12'd1, 12'd1, 12'd4);
    pair(0, 12'h010, 12'h020, {LANES{16'h2000}}, {LANES{16'h2000}});
    pair(0, 12'h011, 12'h021, {LANES{16'h2000}}, {LANES{16'h2000}});
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk1("abort_busy", busy0, 1'b0);
    chk1("abort_rdy", if0.cfg_ready, 1'b1);
    chkw("abort_dout", if0.d_out, '0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus(1'b1, TW'(12'h012 + k / 2), TW'(12'h022 + k / 2), rnd_bus(), rnd_bus());
      seen = seen | if0.out_valid;
    end
    chk1("abort_no_vld", seen, 1'b0);

    for (int c = 0; c < 25; c++) begin
      ins = 3'($urandom);
      ta  = TW'($urandom);
      tb_ = ($urandom_range(0, 3) == 0) ? ta : TW'($urandom);
      sa  = $urandom_range(0, 1) ? TW'($urandom) : TW'($urandom_range(0, 2));
      sb  = ($urandom_range(0, 3) == 0) ? sa : TW'($urandom);
      lim = TW'($urandom_range(0, 5));
      cfg(ins, ta, tb_, sa, sb, lim);
      model_clr();
      for (int k = 0; k < int'(lim); k++) begin
        xa = rnd_bus();
        if (ta == tb_) begin
          xb = xa;
          pair(3, ta, tb_, xa, xb);
        end else begin
          xb = rnd_bus();
          pair($urandom_range(0, 2), ta, tb_, xa, xb);
        end
        add_pair(ins[1:0], xa, xb);
        ta  = ta + sa;
        tb_ = tb_ + sb;
      end
      wait_done($sformatf("rnd%0d", c), model_out(ins[2]), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_lane_array.md
NODE_LANE_ARRAY -- requirements
Module: node_lane_array

Interface
REQ-001 SHALL have parameter LANES, 8, number of parallel lanes.
REQ-002 SHALL have parameter DATA_W, 16, two's-complement lane word, Q(DATA_W-FRAC_W).FRAC_W.
REQ-003 SHALL have parameter FRAC_W, 14, fraction bits.
REQ-004 SHALL have parameter TAG_W, 12, tag/stride/iteration width.
REQ-005 SHALL have parameter GUARD_W, 8, accumulator guard bits; ACC_W = 2*DATA_W+GUARD_W.
REQ-006 SHALL use one clock; reset is synchronous and active-low; ports are clk and rst.
REQ-007 Ports: clk in 1 clock; rst in 1 sync active-low reset.
REQ-008 Ports: prev_enable in 1 chain grant from upstream; next_enable out 1 chain grant downstream.
REQ-009 Ports: cfg_valid in 1; cfg_ready out 1; cfg_instr in 3 ({relu, op[1:0]}); cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim in TAG_W each.
REQ-010 Ports: bus_valid in 1; bus_tag0, bus_tag1 in TAG_W; bus_d0, bus_d1 in LANES*DATA_W, lane i at [i*DATA_W +: DATA_W].
REQ-011 Ports: out_valid out 1; out_ready in 1; d_out out LANES*DATA_W; busy out 1 (state != IDLE).

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE.
REQ-013 cfg_ready = (state==IDLE) & prev_enable; config accepted on cfg_valid & cfg_ready: latch all cfg fields, clear accumulators, iter_count=0, operand slots empty, go RUN.
REQ-014 next_enable = prev_enable & busy; an idle block withholds the grant so only the first idle block in the chain claims a config.
REQ-015 In RUN, operand A SHALL be captured (all lanes) when bus_valid and slot A empty and a bus tag equals tag_a; bus0 has priority if both buses match.
REQ-016 Operand B SHALL be captured identically against tag_b; A and B may capture in the same cycle, from the same bus if tag_a==tag_b.
REQ-017 Cycle after both slots full: accumulate, empty both slots, tag_a+=stride_a, tag_b+=stride_b (mod 2^TAG_W), iter_count+=1.
REQ-018 op 00 MAC: acc += (a*b)>>>FRAC_W; 01 ADD: acc += a+b; 10 SUB: acc += a-b; 11 ABSDIFF: acc += |a-b|; sign-extended to ACC_W.
REQ-019 When iter_count reaches iter_lim after an update, go DONE; cfg_iter_lim=0 SHALL go DONE on the cycle after acceptance with zero result, no operands consumed.
REQ-020 Output per lane: round half up at bit 0 of the FRAC_W-aligned accumulator is not applied for MAC (shift truncates); saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if relu, negatives become 0.
REQ-021 In DONE, out_valid=1 with d_out stable until out_ready; on out_valid & out_ready go IDLE, d_out retained, out_valid=0 next cycle.
REQ-022 Bus words while IDLE or DONE, or while a slot is full, SHALL be ignored; no buffering.
REQ-023 cfg_valid while busy SHALL be ignored (cfg_ready=0).

Reset
REQ-024 On rst==0 at clk edge: state=IDLE, accumulators, operand slots, tags, strides, iter_count, iter_lim, instr, d_out all 0; out_valid=0; cfg_ready follows prev_enable next cycle.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort without emitting a result.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, op codes (OP_MAC, OP_ADD, OP_SUB, OP_ABSDIFF), and the ACC_W formula.
REQ-027 One sub-module node_lane SHALL implement a single lane: operand slots' data, accumulator, op, saturate/relu; instantiated LANES times; control/tag logic is shared in the top.

Verification
REQ-028 MAC, tags a=0x010 b=0x020, strides 1, lim 3, all lanes a=b=0x2000 -> after 3 matched pairs d_out lanes = 0x3000, out_valid.
REQ-029 MAC lim 4, a=0x4000 b=0x2000 -> sum 2.0 saturates, lanes = 0x7FFF; same with b=0xE000 and relu=1 -> lanes = 0x0000.
REQ-030 Tag_a arrives on bus1 and tag_b on bus0 same cycle -> both captured, cross-matched, one update next cycle; tag_a=0xFFF stride 2 -> next tag 0x001.
REQ-031 Two chained blocks, two configs back-to-back -> first block claims first, second claims second; out_ready held low 5 cycles -> d_out stable, out_valid held.
REQ-032 rst low during RUN after 2 of 4 iterations -> IDLE, out_valid never asserts; cfg_iter_lim=0 -> out_valid on cycle 2 after acceptance, lanes 0.
